// File: rtl/instr_fetcher_if.sv
// Instruction-memory read channel (AXI-lite style, read only).
// master: fetcher drives address/ready; slave: memory drives data/resp.
interface instr_fetcher_if;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rready;

    modport master (
        output mem_arvalid,
        output mem_araddr,
        input  mem_arready,
        input  mem_rvalid,
        input  mem_rdata,
        input  mem_rresp,
        output mem_rready
    );

    modport slave (
        input  mem_arvalid,
        input  mem_araddr,
        output mem_arready,
        output mem_rvalid,
        output mem_rdata,
        output mem_rresp,
        input  mem_rready
    );
endinterface

// File: rtl/instr_fetcher.sv
// Instruction fetch unit: picks the fetch PC, reads one word over the
// instruction-memory read channel and presents pc/instr_raw/fault
// with a one-cycle completed pulse.
// Ports: clk, rstn (async active-low); enabled/redirect_valid/
// redirect_pc from the core controller; mem (read channel master);
// completed/pc/instr_raw/fault/busy towards the decoder.
module instr_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enabled,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    instr_fetcher_if.master        mem,
    output logic                   completed,
    output logic [31:0]            pc,
    output logic [31:0]            instr_raw,
    output logic [1:0]             fault,
    output logic                   busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_FAULT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] seq_pc_q, seq_pc_d;
    logic        first_q, first_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic        rready_q, rready_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] target;

    // Sequential PC wraps modulo 2^32.
    always_comb begin
        target = seq_pc_q + 32'd4;
        if (redirect_valid) begin
            target = redirect_pc;
        end else if (first_q) begin
            target = RESET_PC;
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_pc_d  = seq_pc_q;
        first_d   = first_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rready_d  = rready_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        fault_d   = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (enabled) begin
                    seq_pc_d = target;
                    first_d  = 1'b0;
                    if (target[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = target;
                        state_d   = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (mem.mem_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (mem.mem_rvalid) begin
                    rready_d = 1'b0;
                    pc_d     = seq_pc_q;
                    state_d  = S_DONE;
                    if (mem.mem_rresp == 2'b00) begin
                        instr_d = mem.mem_rdata;
                        fault_d = 2'b00;
                    end else begin
                        instr_d = NOP_WORD;
                        fault_d = 2'b10;
                    end
                end
            end
            // Misaligned target: one cycle in place of the bus access,
            // no request is ever issued.
            S_FAULT: begin
                pc_d    = seq_pc_q;
                instr_d = NOP_WORD;
                fault_d = 2'b01;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            seq_pc_q  <= RESET_PC;
            first_q   <= 1'b1;
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            rready_q  <= 1'b0;
            pc_q      <= 32'd0;
            instr_q   <= 32'd0;
            fault_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            seq_pc_q  <= seq_pc_d;
            first_q   <= first_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            fault_q   <= fault_d;
        end
    end

    assign mem.mem_arvalid = arvalid_q;
    assign mem.mem_araddr  = araddr_q;
    assign mem.mem_rready  = rready_q;
    assign completed       = (state_q == S_DONE);
    assign busy            = (state_q != S_IDLE);
    assign pc              = pc_q;
    assign instr_raw       = instr_q;
    assign fault           = fault_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Self-checking bench for instr_fetcher: directed vector table,
// hand-written reset sequences and randomized fetches vs a PC model.
module tb_instr_fetcher;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        completed;
    logic [31:0] pc;
    logic [31:0] instr_raw;
    logic [1:0]  fault;
    logic        busy;

    int checks = 0;
    int failures = 0;

    instr_fetcher_if mem ();

    instr_fetcher #(.RESET_PC(RPC), .NOP_WORD(NOP)) dut (
        .clk(clk),
        .rstn(rstn),
        .enabled(enabled),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mem(mem),
        .completed(completed),
        .pc(pc),
        .instr_raw(instr_raw),
        .fault(fault),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: architectural fetch-PC rules only.
    bit          m_first;
    logic [31:0] m_seq;

    function automatic logic [31:0] model_step(input bit rv,
                                               input logic [31:0] rpc);
        logic [31:0] t;
        if (rv) t = rpc;
        else if (m_first) t = RPC;
        else t = m_seq + 32'd4;
        m_seq = t;
        m_first = 1'b0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, {31'd0, mem.mem_arvalid}, 32'd0);
        chk({tag, "_araddr"}, mem.mem_araddr, 32'd0);
        chk({tag, "_rready"}, {31'd0, mem.mem_rready}, 32'd0);
        chk({tag, "_completed"}, {31'd0, completed}, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_instr"}, instr_raw, 32'd0);
        chk({tag, "_fault"}, {30'd0, fault}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Called #1 after an edge with the DUT idle. Plays the memory
    // with the given wait states and checks timing and results.
    task automatic do_fetch(input bit rv, input logic [31:0] rpc,
                            input int aw, input int rw,
                            input logic [1:0] resp,
                            input logic [31:0] rdata, input bit noise,
                            input logic [31:0] eaddr,
                            input logic [31:0] epc,
                            input logic [31:0] einstr,
                            input logic [1:0] efault, input int elat,
                            input bit emem);
        int c;
        int awc;
        int rwc;
        int ar_cycles;
        bit saw_ar;
        bit done;
        logic [31:0] hpc;
        logic [31:0] hin;
        logic [1:0] hf;
        awc = aw;
        rwc = rw;
        ar_cycles = 0;
        saw_ar = 1'b0;
        done = 1'b0;
        enabled = 1'b1;
        redirect_valid = rv;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
        enabled = 1'b0;
        redirect_valid = 1'b0;
        c = 1;
        while (!done) begin
            if (mem.mem_arvalid) begin
                saw_ar = 1'b1;
                ar_cycles++;
                chk("araddr", mem.mem_araddr, eaddr);
                if (awc == 0) mem.mem_arready = 1'b1;
                else begin
                    mem.mem_arready = noise ? 1'($urandom % 2) & 1'b0 : 1'b0;
                    awc--;
                end
            end else begin
                mem.mem_arready = 1'b0;
            end
            if (mem.mem_rready) begin
                if (rwc == 0) begin
                    mem.mem_rvalid = 1'b1;
                    mem.mem_rdata = rdata;
                    mem.mem_rresp = resp;
                end else begin
                    mem.mem_rvalid = 1'b0;
                    rwc--;
                end
            end else begin
                mem.mem_rvalid = noise ? 1'($urandom % 2) : 1'b0;
                mem.mem_rdata = $urandom;
                mem.mem_rresp = 2'($urandom);
            end
            if (completed) begin
                enabled = 1'b0;
                chk("latency", c, elat);
                chk("pc", pc, epc);
                chk("instr_raw", instr_raw, einstr);
                chk("fault", {30'd0, fault}, {30'd0, efault});
                chk("mem_used", {31'd0, saw_ar}, {31'd0, emem});
                if (emem) chk("ar_cycles", ar_cycles, aw + 1);
                done = 1'b1;
            end else if (c > 60) begin
                checks++;
                failures++;
                $display("FAIL timeout actual=%0d cycles required<=%0d",
                         c, elat);
                done = 1'b1;
            end else begin
                chk("busy", {31'd0, busy}, 32'd1);
                if (noise) begin
                    enabled = 1'($urandom % 2);
                    redirect_valid = 1'($urandom % 2);
                    redirect_pc = $urandom;
                end
                @(posedge clk);
                #1;
                c++;
            end
        end
        hpc = pc;
        hin = instr_raw;
        hf = fault;
        mem.mem_arready = 1'b0;
        mem.mem_rvalid = 1'b0;
        enabled = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_arvalid", {31'd0, mem.mem_arvalid}, 32'd0);
        chk("hold_pc", pc, hpc);
        chk("hold_instr", instr_raw, hin);
        chk("hold_fault", {30'd0, fault}, {30'd0, hf});
    endtask

    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        int          aw;
        int          rw;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          noise;
        logic [31:0] eaddr;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [1:0]  efault;
        int          elat;
        bit          emem;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] t;
        logic [31:0] ei;
        logic [1:0] ef;
        bit rv;
        logic [31:0] rpc;
        int aw;
        int rw;
        logic [1:0] resp;
        logic [31:0] rd;
        bit mis;

        tbl[0] = '{0, 32'h0, 0, 0, 2'b00, 32'h00500093, 0,
                   32'h0, 32'h0, 32'h00500093, 2'b00, 3, 1};
        tbl[1] = '{0, 32'h0, 3, 0, 2'b00, 32'h00A00113, 0,
                   32'h4, 32'h4, 32'h00A00113, 2'b00, 6, 1};
        tbl[2] = '{1, 32'h100, 0, 2, 2'b00, 32'h11111111, 0,
                   32'h100, 32'h100, 32'h11111111, 2'b00, 5, 1};
        tbl[3] = '{0, 32'h0, 1, 1, 2'b00, 32'h22222222, 0,
                   32'h104, 32'h104, 32'h22222222, 2'b00, 5, 1};
        tbl[4] = '{1, 32'h102, 0, 0, 2'b00, 32'h0, 0,
                   32'h0, 32'h102, NOP, 2'b01, 2, 0};
        tbl[5] = '{1, 32'h200, 2, 2, 2'b10, 32'hDEADBEEF, 1,
                   32'h200, 32'h200, NOP, 2'b10, 7, 1};
        tbl[6] = '{1, 32'hFFFFFFFC, 0, 0, 2'b00, 32'h33333333, 0,
                   32'hFFFFFFFC, 32'hFFFFFFFC, 32'h33333333, 2'b00, 3, 1};
        tbl[7] = '{0, 32'h0, 0, 0, 2'b00, 32'h44444444, 0,
                   32'h0, 32'h0, 32'h44444444, 2'b00, 3, 1};

        mem.mem_arready = 1'b0;
        mem.mem_rvalid = 1'b0;
        mem.mem_rdata = 32'd0;
        mem.mem_rresp = 2'b00;
        m_first = 1'b1;
        m_seq = RPC;

        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("post_reset");

        for (int i = 0; i < 8; i++) begin
            t = model_step(tbl[i].rv, tbl[i].rpc);
            do_fetch(tbl[i].rv, tbl[i].rpc, tbl[i].aw, tbl[i].rw,
                     tbl[i].resp, tbl[i].rdata, tbl[i].noise,
                     tbl[i].eaddr, tbl[i].epc, tbl[i].einstr,
                     tbl[i].efault, tbl[i].elat, tbl[i].emem);
        end

        for (int i = 0; i < 40; i++) begin
            rv = ($urandom % 3) == 0;
            rpc = $urandom;
            if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
            if (($urandom % 8) == 0) rpc = 32'hFFFFFFFC;
            aw = $urandom_range(0, 3);
            rw = $urandom_range(0, 3);
            resp = (($urandom % 5) == 0) ? 2'($urandom_range(1, 3))
                                          : 2'b00;
            rd = $urandom;
            t = model_step(rv, rpc);
            mis = (t[1:0] != 2'b00);
            if (mis) begin
                ei = NOP;
                ef = 2'b01;
            end else if (resp != 2'b00) begin
                ei = NOP;
                ef = 2'b10;
            end else begin
                ei = rd;
                ef = 2'b00;
            end
            do_fetch(rv, rpc, aw, rw, resp, rd, 1'($urandom % 2), t, t,
                     ei, ef, mis ? 2 : 3 + aw + rw, !mis);
        end

        // Make sure a nonzero result is held, then reset mid-DATA.
        t = model_step(1'b1, 32'h80);
        do_fetch(1'b1, 32'h80, 0, 0, 2'b00, 32'h55555555, 0, 32'h80,
                 32'h80, 32'h55555555, 2'b00, 3, 1);
        enabled = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk);
        #1;
        enabled = 1'b0;
        redirect_valid = 1'b0;
        mem.mem_arready = 1'b1;
        @(posedge clk);
        #1;
        mem.mem_arready = 1'b0;
        chk("middata_rready", {31'd0, mem.mem_rready}, 32'd1);
        rstn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        m_first = 1'b1;
        m_seq = RPC;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        t = model_step(1'b0, 32'h0);
        do_fetch(1'b0, 32'h0, 1, 0, 2'b00, 32'h00100073, 0, t, t,
                 32'h00100073, 2'b00, 4, 1);
        t = model_step(1'b0, 32'h0);
        do_fetch(1'b0, 32'h0, 0, 0, 2'b00, 32'h00000513, 0, t, t,
                 32'h00000513, 2'b00, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
